// File: rtl/cv32e41s_pmr_xlate.sv
// cv32e41s_pmr_xlate -- PMP-style region match, permission check and address
// relocation in a two-stage valid/ready pipeline.
//
//   S1 : region match (lowest index wins), permission verdict, offset decode.
//        cfg_* is sampled here only, so later cfg changes do not affect
//        requests already in flight.
//   S2 : relocated address (modulo 2^34), drives the rsp_* outputs.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid_i/req_ready_o    request handshake
//   req_addr_i/type_i/priv_i   34-bit address, access type, privilege
//   cfg_mode/perm/addr/off_i   per-region config, packed N-wide
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_addr/err/hit/region_o  response fields
//   fault_cnt_o/fault_cnt_clr_i  saturating fault counter and its clear
//
// Optional feature: define CV32E41S_PMR_FAULT_CNT_EN to build the fault
// counter; otherwise fault_cnt_o is tied to 0 and no counter flops exist.

module cv32e41s_pmr_xlate_region #(
  parameter int G = 0
) (
  input  logic [33:0] addr_w,     // request address >> 2
  input  logic [1:0]  mode,
  input  logic [33:0] cfg_addr,
  input  logic [33:0] base_addr,  // previous region's address (TOR base)
  output logic        match
);
  localparam logic [33:0] GMASK = ~((34'd1 << G) - 34'd1);

  logic [33:0] a, top, base, napot_mask;

  always_comb begin
    a          = addr_w & GMASK;
    top        = cfg_addr & GMASK;
    base       = base_addr & GMASK;
    // cfg ^ (cfg+1) sets the trailing ones plus the first zero: the span bits
    napot_mask = ~(cfg_addr ^ (cfg_addr + 34'd1)) & GMASK;
    case (mode)
      2'b01:   match = (a >= base) && (a < top);
      2'b10:   match = (a == top);
      2'b11:   match = ((addr_w & napot_mask) == (cfg_addr & napot_mask));
      default: match = 1'b0;
    endcase
  end
endmodule

module cv32e41s_pmr_xlate #(
  parameter int PMP_NUM_REGIONS = 4,
  parameter int PMP_GRANULARITY = 0,
  parameter int RELOC_ENC       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [33:0]                   req_addr_i,
  input  logic [1:0]                    req_type_i,
  input  logic [1:0]                    req_priv_i,
  input  logic [2*PMP_NUM_REGIONS-1:0]  cfg_mode_i,
  input  logic [3*PMP_NUM_REGIONS-1:0]  cfg_perm_i,
  input  logic [34*PMP_NUM_REGIONS-1:0] cfg_addr_i,
  input  logic [32*PMP_NUM_REGIONS-1:0] cfg_off_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [33:0]                   rsp_addr_o,
  output logic                          rsp_err_o,
  output logic                          rsp_hit_o,
  output logic [3:0]                    rsp_region_o,
  output logic [15:0]                   fault_cnt_o,
  input  logic                          fault_cnt_clr_i
);
  localparam int N = PMP_NUM_REGIONS;

  logic [33:0]  addr_w;
  logic [N-1:0] match;

  assign addr_w = {2'b00, req_addr_i[33:2]};

  for (genvar i = 0; i < N; i++) begin : g_rgn
    logic [33:0] base;
    if (i == 0) begin : g_b0
      assign base = '0;
    end else begin : g_bn
      assign base = cfg_addr_i[34*(i-1) +: 34];
    end
    cv32e41s_pmr_xlate_region #(.G(PMP_GRANULARITY)) u_rgn (
      .addr_w    (addr_w),
      .mode      (cfg_mode_i[2*i +: 2]),
      .cfg_addr  (cfg_addr_i[34*i +: 34]),
      .base_addr (base),
      .match     (match[i])
    );
  end

  // lowest index wins: scan downward so the last write is the lowest hit
  logic        hit, allowed, m_mode, err, sgn;
  logic [3:0]  idx;
  logic [2:0]  sel_perm;
  logic [31:0] sel_off;
  logic [33:0] mag;

  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    sel_perm = '0;
    sel_off  = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (match[i]) begin
        hit      = 1'b1;
        idx      = 4'(i);
        sel_perm = cfg_perm_i[3*i +: 3];
        sel_off  = cfg_off_i[32*i +: 32];
      end
    end
    case (req_type_i)
      2'b00:   allowed = sel_perm[0];
      2'b01:   allowed = sel_perm[1];
      2'b10:   allowed = sel_perm[2];
      default: allowed = 1'b0;
    endcase
    m_mode = (req_priv_i == 2'b11);
    err    = !m_mode && (!hit || !allowed);
    mag    = {3'b000, sel_off[30:0]};
    sgn    = sel_off[31];
    if (RELOC_ENC == 1) begin
      mag = 34'd1 << sel_off[4:0];
      sgn = sel_off[5];
    end else if (RELOC_ENC == 2) begin
      mag = (34'd1 << sel_off[4:0]) + (34'd4 << sel_off[7:5]);
      sgn = sel_off[8];
    end
  end

  // handshake / advance
  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv      = !s2_valid || rsp_ready_i;
  assign s1_adv      = !s1_valid || s2_adv;
  assign req_ready_o = s1_adv;
  assign rsp_valid_o = s2_valid;

  // S1
  logic [33:0] s1_addr, s1_mag;
  logic        s1_err, s1_hit, s1_sgn, s1_reloc;
  logic [3:0]  s1_region;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_mag    <= '0;
      s1_err    <= 1'b0;
      s1_hit    <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_reloc  <= 1'b0;
      s1_region <= '0;
    end else if (s1_adv) begin
      s1_valid <= req_valid_i;
      if (req_valid_i) begin
        s1_addr   <= req_addr_i;
        s1_mag    <= mag;
        s1_err    <= err;
        s1_hit    <= hit;
        s1_sgn    <= sgn;
        s1_reloc  <= !err && !m_mode;  // faults and M-mode pass through
        s1_region <= idx;
      end
    end
  end

  // S2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      rsp_addr_o   <= '0;
      rsp_err_o    <= 1'b0;
      rsp_hit_o    <= 1'b0;
      rsp_region_o <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        rsp_addr_o   <= !s1_reloc ? s1_addr :
                        s1_sgn   ? s1_addr - s1_mag : s1_addr + s1_mag;
        rsp_err_o    <= s1_err;
        rsp_hit_o    <= s1_hit;
        rsp_region_o <= s1_region;
      end
    end
  end

`ifdef CV32E41S_PMR_FAULT_CNT_EN
  logic [15:0] fault_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || fault_cnt_clr_i)
      fault_cnt_q <= '0;
    else if (rsp_valid_o && rsp_ready_i && rsp_err_o && (fault_cnt_q != 16'hFFFF))
      fault_cnt_q <= fault_cnt_q + 16'd1;
  end

  assign fault_cnt_o = fault_cnt_q;
`else
  logic unused_clr;
  assign unused_clr  = fault_cnt_clr_i;
  assign fault_cnt_o = '0;
`endif
endmodule

// File: tb/tb_cv32e41s_pmr_xlate.sv
module tb_cv32e41s_pmr_xlate;
  localparam int N = 4;
  localparam longint M34 = (longint'(1) << 34) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req_valid, rsp_ready, clr;
  logic [33:0]   req_addr;
  logic [1:0]    req_type, req_priv;
  logic [2*N-1:0]  cfg_mode;
  logic [3*N-1:0]  cfg_perm;
  logic [34*N-1:0] cfg_addr;
  logic [32*N-1:0] cfg_off;

  logic [2:0]  rv, rr, re, rh;
  logic [3:0]  rg [3];
  logic [33:0] ra [3];
  logic [15:0] fc [3];

  // one instance per offset encoding, all driven by the same stimulus
  for (genvar k = 0; k < 3; k++) begin : g_dut
    cv32e41s_pmr_xlate #(.PMP_NUM_REGIONS(N), .PMP_GRANULARITY(0), .RELOC_ENC(k)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(rr[k]),
      .req_addr_i(req_addr), .req_type_i(req_type), .req_priv_i(req_priv),
      .cfg_mode_i(cfg_mode), .cfg_perm_i(cfg_perm), .cfg_addr_i(cfg_addr), .cfg_off_i(cfg_off),
      .rsp_valid_o(rv[k]), .rsp_ready_i(rsp_ready),
      .rsp_addr_o(ra[k]), .rsp_err_o(re[k]), .rsp_hit_o(rh[k]), .rsp_region_o(rg[k]),
      .fault_cnt_o(fc[k]), .fault_cnt_clr_i(clr)
    );
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  typedef struct packed {
    logic [33:0] a0, a1, a2;
    logic        err, hit;
    logic [3:0]  rgn;
  } exp_t;

  // Reference: byte-address ranges, first matching region, arithmetic relocation.
  function automatic exp_t model(input logic [33:0] a, input logic [1:0] t, input logic [1:0] p);
    exp_t e;
    longint ab, lo, hi, sz, base, r;
    longint mg [3];
    logic   sg [3];
    logic [33:0] w;
    logic [31:0] o;
    int hit, t1;
    bit m;
    ab = longint'(a);
    hit = -1;
    for (int i = 0; i < N; i++) begin
      if (hit < 0) begin
        w = cfg_addr[34*i +: 34];
        m = 0;
        case (cfg_mode[2*i +: 2])
          2'b01: begin
            lo = 0;
            if (i > 0) lo = longint'(cfg_addr[34*(i-1) +: 34]) * 4;
            hi = longint'(w) * 4;
            m = (ab >= lo) && (ab < hi);
          end
          2'b10: m = (ab / 4) == longint'(w);
          2'b11: begin
            t1 = 0;
            while (t1 < 34 && w[t1]) t1++;
            sz   = longint'(1) << (t1 + 3);
            base = (longint'(w) * 4) & ~(sz - 1);
            m = (ab >= base) && (ab < base + sz);
          end
          default: m = 0;
        endcase
        if (m) hit = i;
      end
    end
    e.hit = (hit >= 0);
    e.rgn = (hit >= 0) ? 4'(hit) : 4'd0;
    e.err = (p != 2'b11) && ((hit < 0) || (t == 2'b11) || !cfg_perm[3*hit + int'(t)]);
    e.a0 = a; e.a1 = a; e.a2 = a;
    if (!e.err && p != 2'b11) begin
      o = cfg_off[32*hit +: 32];
      mg[0] = longint'(o[30:0]);                                    sg[0] = o[31];
      mg[1] = longint'(1) << o[4:0];                                sg[1] = o[5];
      mg[2] = (longint'(1) << o[4:0]) + (longint'(4) << o[7:5]);    sg[2] = o[8];
      r = (sg[0] ? ab - mg[0] : ab + mg[0]) & M34; e.a0 = r[33:0];
      r = (sg[1] ? ab - mg[1] : ab + mg[1]) & M34; e.a1 = r[33:0];
      r = (sg[2] ? ab - mg[2] : ab + mg[2]) & M34; e.a2 = r[33:0];
    end
    return e;
  endfunction

  // scoreboard / compare process
  exp_t q [$];
  exp_t e_pop;
  bit   started = 0, prev_rst = 0, stall = 0;
  logic [15:0] model_cnt = 0;
  logic [33:0] h_a [3];
  logic [2:0]  h_e, h_h;
  logic [3:0]  h_g [3];

  always @(negedge clk) begin
    if (prev_rst) begin
      started = 1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_valid%0d", k), 64'(rv[k]), 0);
        chk($sformatf("rst_ready%0d", k), 64'(rr[k]), 1);
        chk($sformatf("rst_addr%0d", k), 64'(ra[k]), 0);
        chk($sformatf("rst_flags%0d", k), 64'({re[k], rh[k], rg[k]}), 0);
      end
    end
    if (started)
      for (int k = 0; k < 3; k++) chk($sformatf("fault_cnt%0d", k), 64'(fc[k]), 64'(model_cnt));
    if (!rst_n) begin
      q.delete();
      stall = 0;
      model_cnt = 0;
    end else if (started) begin
      if (stall)
        for (int k = 0; k < 3; k++)
          chk($sformatf("stable%0d", k), 64'({rv[k], ra[k], re[k], rh[k], rg[k]}),
              64'({1'b1, h_a[k], h_e[k], h_h[k], h_g[k]}));
      if (rv[0] && rsp_ready) begin
        if (q.size() == 0) chk("pop_empty", 1, 0);
        else begin
          e_pop = q.pop_front();
          chk("rsp_addr_enc0", 64'(ra[0]), 64'(e_pop.a0));
          chk("rsp_addr_enc1", 64'(ra[1]), 64'(e_pop.a1));
          chk("rsp_addr_enc2", 64'(ra[2]), 64'(e_pop.a2));
          for (int k = 0; k < 3; k++)
            chk($sformatf("rsp_flags%0d", k), 64'({rv[k], re[k], rh[k], rg[k]}),
                64'({1'b1, e_pop.err, e_pop.hit, e_pop.rgn}));
`ifdef CV32E41S_PMR_FAULT_CNT_EN
          if (e_pop.err && !clr && model_cnt != 16'hFFFF) model_cnt = model_cnt + 1;
`endif
        end
      end
`ifdef CV32E41S_PMR_FAULT_CNT_EN
      if (clr) model_cnt = 0;
`endif
      if (req_valid && rr[0]) q.push_back(model(req_addr, req_type, req_priv));
      stall = rv[0] && !rsp_ready;
      for (int k = 0; k < 3; k++) begin
        h_a[k] = ra[k]; h_e[k] = re[k]; h_h[k] = rh[k]; h_g[k] = rg[k];
      end
    end
    prev_rst = !rst_n;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int i, input logic [1:0] m, input logic [2:0] p,
                         input logic [33:0] a, input logic [31:0] o);
    cfg_mode[2*i +: 2] = m;
    cfg_perm[3*i +: 3] = p;
    cfg_addr[34*i +: 34] = a;
    cfg_off[32*i +: 32] = o;
  endtask

  // single request; returns at the negedge where the response should be visible
  task automatic run1(input logic [33:0] a, input logic [1:0] t, input logic [1:0] p, input string nm);
    req_addr = a; req_type = t; req_priv = p; req_valid = 1; rsp_ready = 1;
    cyc();
    req_valid = 0;
    @(negedge clk);
    chk({nm, "_lat1"}, 64'(rv[0]), 0);
    cyc();
    @(negedge clk);
    chk({nm, "_lat2"}, 64'(rv[0]), 1);
  endtask

  task automatic rand_cfg();
    logic [33:0] w, na;
    int t;
    w = 0;
    for (int i = 0; i < N; i++) begin
      w = w + 34'($urandom_range(0, 16'h100));
      set_reg(i, 2'($urandom), 3'($urandom), w, $urandom);
      if (cfg_mode[2*i +: 2] == 2'b11) begin
        t  = $urandom_range(0, 6);
        na = 34'($urandom_range(0, 16'h3FF));
        na = (na & ~((34'd1 << (t + 1)) - 1)) | ((34'd1 << t) - 1);
        cfg_addr[34*i +: 34] = na;
      end
    end
  endtask

  exp_t pe;

  initial begin
    rst_n = 0; req_valid = 0; rsp_ready = 1; clr = 0;
    req_addr = 0; req_type = 0; req_priv = 0;
    cfg_mode = 0; cfg_perm = 0; cfg_addr = 0; cfg_off = 0;
    repeat (3) cyc();
    rst_n = 1;
    cyc();

    // linear relocation
    set_reg(0, 2'b01, 3'b001, 34'h400, 32'h0000_2000);
    req_addr = 34'h800; req_type = 0; req_priv = 0;
    pe = model(34'h800, 2'b00, 2'b00);
    chk("model_lin", 64'({pe.a0, pe.err}), 64'({34'h2800, 1'b0}));
    run1(34'h800, 2'b00, 2'b00, "lin");
    chk("lin_addr", 64'(ra[0]), 64'h2800);
    chk("lin_err_rgn", 64'({re[0], rg[0]}), 0);

    // power-of-two subtract with wrap; mixed add
    cfg_off[31:0] = 32'h24;
    pe = model(34'h8, 2'b00, 2'b00);
    chk("model_pow2", 64'(pe.a1), 64'h3_FFFF_FFF8);
    run1(34'h8, 2'b00, 2'b00, "pow2");
    chk("pow2_addr", 64'(ra[1]), 64'h3_FFFF_FFF8);
    cfg_off[31:0] = 32'h62;
    pe = model(34'h100, 2'b00, 2'b00);
    chk("model_mix", 64'(pe.a2), 64'h124);
    run1(34'h100, 2'b00, 2'b00, "mix");
    chk("mix_addr", 64'(ra[2]), 64'h124);
    cfg_off[31:0] = 32'h2000;

    // permission fault, M-mode bypass, priority, TOR base, no match, reserved type
    set_reg(1, 2'b01, 3'b111, 34'h800, 32'h10);
    run1(34'h800, 2'b01, 2'b00, "permf");
    chk("permf", 64'({re[0], rh[0], rg[0], ra[0]}), 64'({1'b1, 1'b1, 4'd0, 34'h800}));
    run1(34'h800, 2'b01, 2'b11, "mmode");
    chk("mmode", 64'({re[0], rh[0], rg[0], ra[0]}), 64'({1'b0, 1'b1, 4'd0, 34'h800}));
    run1(34'h1000, 2'b01, 2'b00, "tor1");
    chk("tor1", 64'({re[0], rh[0], rg[0], ra[0]}), 64'({1'b0, 1'b1, 4'd1, 34'h1010}));
    run1(34'h3000, 2'b00, 2'b00, "nomatch");
    chk("nomatch", 64'({re[0], rh[0], rg[0], ra[0]}), 64'({1'b1, 1'b0, 4'd0, 34'h3000}));
    run1(34'h1000, 2'b11, 2'b00, "rsvd");
    chk("rsvd", 64'({re[0], ra[0]}), 64'({1'b1, 34'h1000}));

    // backpressure: 3 back-to-back, response side stalled 5 cycles
    rsp_ready = 0; req_valid = 1; req_type = 0; req_priv = 0;
    req_addr = 34'h10; cyc();
    req_addr = 34'h20; cyc();
    req_addr = 34'h30;
    chk("bp_ready_low", 64'(rr[0]), 0);
    repeat (5) cyc();
    rsp_ready = 1;
    cyc();
    req_valid = 0;
    repeat (5) cyc();
    chk("bp_drain", 64'(q.size()), 0);

    // cfg change right after S1 capture must not affect the request
    req_addr = 34'h800; req_type = 0; req_valid = 1;
    cyc();
    req_valid = 0;
    cfg_off[31:0] = 32'h5000;
    cyc();
    @(negedge clk);
    chk("cfg_inflight", 64'({rv[0], ra[0]}), 64'({1'b1, 34'h2800}));
    cyc();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) rand_cfg();
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = ($urandom_range(0, 3) != 0) ? 34'($urandom_range(0, 16'h1800))
                                              : {2'($urandom), 32'($urandom)};
      req_type  = 2'($urandom);
      req_priv  = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rsp_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst_n = 1; clr = 0; req_valid = 0; rsp_ready = 1;
    repeat (4) cyc();
    chk("rand_drain", 64'(q.size()), 0);

    // fault counter: all regions off, so every unprivileged access faults
    cfg_mode = 0; req_priv = 0; req_type = 0; req_valid = 1;
`ifdef CV32E41S_PMR_FAULT_CNT_EN
    clr = 1; cyc(); clr = 0;
    repeat (65540) cyc();
    @(negedge clk);
    chk("cnt_sat", 64'(fc[0]), 64'hFFFF);
    cyc();
    clr = 1; cyc(); clr = 0;
    @(negedge clk);
    chk("cnt_clr_vs_inc", 64'(fc[0]), 0);
`else
    repeat (8) cyc();
    @(negedge clk);
    chk("cnt_tied", 64'(fc[0]), 0);
`endif
    req_valid = 0;
    repeat (4) cyc();
    chk("final_drain", 64'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cv32e41s_pmr_xlate.md
CV32E41S_PMR_XLATE -- requirements
Module: cv32e41s_pmr_xlate

Interface
REQ-001 SHALL have parameter PMP_NUM_REGIONS, default 4, number of regions (legal 1..16).
REQ-002 SHALL have parameter PMP_GRANULARITY, default 0, granule is 2^(G+2) bytes; compares use address bits [33:G+2].
REQ-003 SHALL have parameter RELOC_ENC, default 0, offset encoding: 0 linear, 1 power-of-two, 2 mixed.
REQ-004 SHALL have ports (N = PMP_NUM_REGIONS):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_addr_i  in  34  physical address.
- req_type_i  in  2  00 read, 01 write, 10 exec, 11 reserved.
- req_priv_i  in  2  privilege level; 2'b11 is M-mode.
- cfg_mode_i  in  2*N  per region: 00 OFF, 01 TOR, 10 NA4, 11 NAPOT.
- cfg_perm_i  in  3*N  per region {x,w,r}.
- cfg_addr_i  in  34*N  per-region address, PMP format.
- cfg_off_i  in  32*N  per-region relocation offset.
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- rsp_addr_o  out  34  relocated address.
- rsp_err_o  out  1  access fault.
- rsp_hit_o  out  1  a region matched.
- rsp_region_o  out  4  matching region index, 0 when no match.
- fault_cnt_o  out  16  fault counter.
- fault_cnt_clr_i  in  1  counter clear.

Function
REQ-005 SHALL be a two-stage pipeline. S1 registers the match result, permission verdict and decoded offset. S2 registers the relocated address.
REQ-006 SHALL present rsp_valid_o exactly 2 cycles after a request handshake when rsp_ready_i is held high, and SHALL sustain 1 request per cycle.
REQ-007 SHALL advance a stage when the stage is empty or its successor advances; S2 advances on rsp_valid_o && rsp_ready_i.
REQ-008 SHALL set req_ready_o = !s1_valid || S1 advances (combinational from rsp_ready_i).
REQ-009 SHALL hold all rsp_* outputs stable while rsp_valid_o && !rsp_ready_i.
REQ-010 SHALL match regions with PMP semantics:
- TOR: [addr[i-1], addr[i]), with a base of 0 for i = 0.
- NA4 and NAPOT: masked equality, with the trailing-ones mask.
- OFF: never matches.
REQ-011 SHALL give priority to the lowest-index matching region.
REQ-012 SHALL decide faults as follows:
- M-mode never faults and is never relocated (rsp_addr_o = req_addr_i); rsp_hit_o and rsp_region_o are still reported.
- Non-M with no match faults.
- Non-M with a match faults unless the matching region's perm bit for req_type_i is set.
- req_type_i = 11 always faults in non-M.
REQ-013 SHALL decode the offset magnitude and sign by RELOC_ENC:
- Linear: magnitude = off[30:0], sign = off[31].
- Power-of-two: magnitude = 1<<off[4:0], sign = off[5].
- Mixed: magnitude = (1<<off[4:0]) + (4<<off[7:5]), sign = off[8].
- Sign 0 adds, sign 1 subtracts.
REQ-014 SHALL compute the relocated address modulo 2^34, wrapping silently on overflow or underflow.
REQ-015 SHALL return rsp_addr_o = req_addr_i unrelocated on a fault.
REQ-016 SHALL sample cfg_* only at the S1 capture edge. A cfg change with requests in flight SHALL NOT affect those requests.
REQ-017 SHALL add 1 to fault_cnt_o on each response handshake with rsp_err_o = 1, saturating at 16'hFFFF.
REQ-018 SHALL give fault_cnt_clr_i priority over a simultaneous increment, leaving the result 0.

Reset
REQ-019 SHALL, on rst_n low at a clock edge:
- clear s1_valid and s2_valid;
- set rsp_valid_o = 0, rsp_err_o = 0, rsp_hit_o = 0, rsp_region_o = 0, rsp_addr_o = 0, fault_cnt_o = 0;
- set req_ready_o = 1 from the first cycle after reset.
REQ-020 SHALL discard in-flight requests on reset mid-operation, with no response produced.

Configuration
REQ-021 SHALL gate the fault counter with macro CV32E41S_PMR_FAULT_CNT_EN.
- Defined: REQ-017 and REQ-018 apply.
- Undefined: fault_cnt_o is tied to 0, fault_cnt_clr_i is ignored, and no counter flops exist.

Verification
REQ-022 SHALL cover linear relocation:
- Setup: region0 TOR 0x0000_1000 (cfg_addr 0x400), perm r, off 0x0000_2000, priv U.
- Stimulus: read 0x800.
- Required: after 2 cycles rsp_addr_o = 0x2800, rsp_err_o = 0, rsp_region_o = 0.
REQ-023 SHALL cover power-of-two subtraction with wrap:
- Setup: RELOC_ENC = 1, off = 0x24 (sign 1, shift 4), priv U.
- Stimulus: address 0x8.
- Required: rsp_addr_o = 0x3_FFFF_FFF8.
REQ-024 SHALL cover a permission fault and M-mode bypass:
- U write to an r-only region -> rsp_err_o = 1, address unrelocated.
- Same request in M-mode -> rsp_err_o = 0, address unrelocated.
REQ-025 SHALL cover backpressure:
- Stimulus: 3 back-to-back requests with rsp_ready_i low for 5 cycles.
- Required: req_ready_o drops after 2 acceptances, outputs are stable, all 3 responses arrive in order with none lost or duplicated.
REQ-026 SHALL cover a config change in flight:
- Stimulus: change cfg_off_i in the cycle after S1 capture.
- Required: the response uses the old offset.
REQ-027 SHALL cover counter saturation and clear (macro defined):
- Preload 0xFFFF via faults, then one more fault -> counter stays 0xFFFF.
- Clear coincident with a fault -> counter reads 0.
